int_call_sequencer: RTL

Multi-cycle controller for the processor's control-transfer instructions: CALL, RET, RTI, and hardware interrupt entry. It sits beside the decode stage. Once it accepts a request it stalls fetch and steps the stack, memory and PC-select datapath through the push/pop sequence one cycle at a time. Interrupts are latched as pending and serviced only from IDLE, i.e. at an instruction boundary.

---
 rtl/int_call_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/int_call_sequencer.sv
// int_call_sequencer: steps CALL/RET/RTI and interrupt entry through the stack.
// Build option NESTED_INT_EN: interrupts are never masked, so ISRs may nest.
module int_call_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       call_req,
  input  logic       ret_req,
  input  logic       rti_req,
  output logic       busy,
  output logic [1:0] stack_op,
  output logic [1:0] data_sel,
  output logic [1:0] pc_sel,
  output logic       pc_load,
  output logic       vec_read,
  output logic       int_ack,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, C_PH, C_PL, C_JMP,
    I_PF, I_PH, I_PL, I_VEC, I_JMP,
    R_PL, R_PH, R_JMP,
    T_PL, T_PH, T_PF, T_JMP
  } state_t;

  state_t state, nxt;
  logic   pending, mask, enter_int;

  always_comb begin
    nxt       = state;
    enter_int = 1'b0;
    unique case (state)
      IDLE: begin
        if (rti_req)       nxt = T_PL;
        else if (ret_req)  nxt = R_PL;
        else if (call_req) nxt = C_PH;
        else if (pending) begin
          nxt       = I_PF;
          enter_int = 1'b1;
        end
      end
      C_PH:  nxt = C_PL;
      C_PL:  nxt = C_JMP;
      I_PF:  nxt = I_PH;
      I_PH:  nxt = I_PL;
      I_PL:  nxt = I_VEC;
      I_VEC: nxt = I_JMP;
      R_PL:  nxt = R_PH;
      R_PH:  nxt = R_JMP;
      T_PL:  nxt = T_PH;
      T_PH:  nxt = T_PF;
      T_PF:  nxt = T_JMP;
      C_JMP, I_JMP, R_JMP, T_JMP: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      mask     <= 1'b0;
      busy     <= 1'b0;
      stack_op <= 2'b00;
      data_sel <= 2'b00;
      pc_sel   <= 2'b00;
      pc_load  <= 1'b0;
      vec_read <= 1'b0;
      int_ack  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      if (enter_int)
        pending <= 1'b0;
      else if (int_req && !mask)
        pending <= 1'b1;
`ifdef NESTED_INT_EN
      mask <= 1'b0;
`else
      if (enter_int)
        mask <= 1'b1;
      else if (state == T_JMP)
        mask <= 1'b0;
`endif
      busy     <= (nxt != IDLE);
      stack_op <= 2'b00;
      data_sel <= 2'b00;
      pc_sel   <= 2'b00;
      pc_load  <= 1'b0;
      vec_read <= 1'b0;
      int_ack  <= 1'b0;
      done     <= 1'b0;
      unique case (nxt)
        IDLE: ;
        C_PH, I_PH: begin
          stack_op <= 2'b01;
          data_sel <= 2'b00;
        end
        C_PL, I_PL: begin
          stack_op <= 2'b01;
          data_sel <= 2'b01;
        end
        I_PF: begin
          stack_op <= 2'b01;
          data_sel <= 2'b10;
          int_ack  <= 1'b1;
        end
        I_VEC: vec_read <= 1'b1;
        C_JMP: begin
          pc_sel  <= 2'b01;
          pc_load <= 1'b1;
          done    <= 1'b1;
        end
        I_JMP: begin
          pc_sel  <= 2'b10;
          pc_load <= 1'b1;
          done    <= 1'b1;
        end
        R_JMP, T_JMP: begin
          pc_sel  <= 2'b11;
          pc_load <= 1'b1;
          done    <= 1'b1;
        end
        R_PL, T_PL: begin
          stack_op <= 2'b10;
          data_sel <= 2'b01;
        end
        R_PH, T_PH: begin
          stack_op <= 2'b10;
          data_sel <= 2'b00;
        end
        T_PF: begin
          stack_op <= 2'b10;
          data_sel <= 2'b10;
        end
      endcase
    end
  end

endmodule
